iod_tx_train_gen: RTL

IOD_TX_TRAIN_GEN -- requirements
Module: iod_tx_train_gen

---
 rtl/iod_tx_train_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iod_tx_train_gen.sv
// Link-training pattern generator ahead of an IOD TX gearbox: walks IDLE -> TRAIN -> SYNC -> DATA
// and drives a registered per-lane word (training pattern, sync marker or payload) every SCLK.
module iod_tx_train_gen #(
  parameter int unsigned LANES            = 4,
  parameter int unsigned FABRIC_RATIO     = 4,
  parameter logic [2*FABRIC_RATIO-1:0] TRAIN_WORD = 8'hB4,
  parameter logic [2*FABRIC_RATIO-1:0] SYNC_WORD  = 8'hF0,
  parameter int unsigned MIN_TRAIN_CYCLES = 64,
  parameter int unsigned SYNC_CYCLES      = 4,
  parameter int unsigned TIMEOUT_WIDTH    = 16
) (
  input  logic                                SCLK,
  input  logic                                RESET,
  input  logic                                TRAIN_START,
  input  logic                                RX_ALIGN_DONE,
  input  logic [LANES*2*FABRIC_RATIO-1:0]     TX_DATA_IN,
  input  logic                                TX_DATA_VALID,
  output logic                                TX_DATA_READY,
  output logic [LANES*2*FABRIC_RATIO-1:0]     TXD,
  output logic                                TX_TRAINING,
  output logic                                TX_LINK_UP,
  output logic                                TRAIN_ERR
);

  localparam int unsigned W      = 2 * FABRIC_RATIO;
  localparam int unsigned DATA_W = LANES * W;
  localparam int unsigned TCW    = $clog2(MIN_TRAIN_CYCLES) + 1;
  localparam int unsigned SCW    = $clog2(SYNC_CYCLES) + 1;

  localparam logic [TCW-1:0]           TRAIN_LAST = TCW'(MIN_TRAIN_CYCLES - 1);
  localparam logic [SCW-1:0]           SYNC_LAST  = SCW'(SYNC_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST   = {TIMEOUT_WIDTH{1'b1}} - TIMEOUT_WIDTH'(1);
  localparam logic [DATA_W-1:0]        TRAIN_PAT  = {LANES{TRAIN_WORD}};
  localparam logic [DATA_W-1:0]        SYNC_PAT   = {LANES{SYNC_WORD}};

  typedef enum logic [1:0] {IDLE, TRAIN, SYNC, DATA} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     clr_cnt;
  logic                     set_err;
  logic                     start_d;
  logic                     start_rise;
  logic [TCW-1:0]           train_cnt;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [SCW-1:0]           sync_cnt;

  function automatic logic [TCW-1:0] sat_inc_train(input logic [TCW-1:0] v);
    return (&v) ? v : v + TCW'(1);
  endfunction

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc_tmo(input logic [TIMEOUT_WIDTH-1:0] v);
    return (&v) ? v : v + TIMEOUT_WIDTH'(1);
  endfunction

  // start_d is cleared by RESET, so a request already high when reset drops still counts as an edge
  assign start_rise = TRAIN_START & ~start_d;

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: if (start_rise) begin
        state_nxt = TRAIN;
        clr_cnt   = 1'b1;
      end
      TRAIN: begin
        // alignment exit takes priority over a coincident timeout
        if (train_cnt >= TRAIN_LAST && RX_ALIGN_DONE) begin
          state_nxt = SYNC;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
        end
      end
      SYNC: begin
        if (!RX_ALIGN_DONE) begin
          state_nxt = TRAIN;
          clr_cnt   = 1'b1;
        end else if (sync_cnt == SYNC_LAST) begin
          state_nxt = DATA;
        end
      end
      DATA: if (!RX_ALIGN_DONE || start_rise) begin
        state_nxt = TRAIN;
        clr_cnt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state         <= IDLE;
      start_d       <= 1'b0;
      train_cnt     <= '0;
      tmo_cnt       <= '0;
      sync_cnt      <= '0;
      TXD           <= '0;
      TX_TRAINING   <= 1'b0;
      TX_LINK_UP    <= 1'b0;
      TX_DATA_READY <= 1'b0;
      TRAIN_ERR     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_d <= TRAIN_START;

      if (clr_cnt) begin
        train_cnt <= '0;
        tmo_cnt   <= '0;
      end else if (state == TRAIN) begin
        train_cnt <= sat_inc_train(train_cnt);
        tmo_cnt   <= sat_inc_tmo(tmo_cnt);
      end

      sync_cnt <= (state == SYNC && state_nxt == SYNC) ? sync_cnt + SCW'(1) : '0;

      if (set_err) begin
        TRAIN_ERR <= 1'b1;
      end else if (state == IDLE && state_nxt == TRAIN) begin
        TRAIN_ERR <= 1'b0;
      end

      TX_TRAINING   <= (state_nxt == TRAIN);
      TX_LINK_UP    <= (state_nxt == DATA);
      TX_DATA_READY <= (state_nxt == DATA);

      // payload is only taken in a cycle where READY was already presented
      case (state_nxt)
        TRAIN:   TXD <= TRAIN_PAT;
        SYNC:    TXD <= SYNC_PAT;
        DATA:    TXD <= (TX_DATA_READY && TX_DATA_VALID) ? TX_DATA_IN : '0;
        default: TXD <= '0;
      endcase
    end
  end

endmodule
